barrel_shifter_pipe: RTL and testbench

Parametrised, pipelined barrel shifter for the ALU datapath. It generalises the fixed 32-bit, left-only combinational shifter to any power-of-two width. It supports four shift/rotate modes and places one register per log2 stage, giving full throughput at high clock rates. A valid/ready handshake on both sides, plus a sideband tag, lets it sit between the operand-issue logic and the ALU result mux.

---
 rtl/bshift_pkg.sv | 26 ++
 rtl/bshift_stage.sv | 81 ++++++++
 rtl/barrel_shifter_pipe.sv | 86 ++++++++
 tb/tb_barrel_shifter_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bshift_pkg.sv
// ============================================================================
//  Module      : bshift_pkg
//  Description : Shared op encoding and width-legality check for the
//                pipelined barrel shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bshift_pkg;

    typedef enum logic [1:0] {
        BSH_SLL = 2'b00,
        BSH_SRL = 2'b01,
        BSH_SRA = 2'b10,
        BSH_ROL = 2'b11
    } bsh_op_e;

    // A legal configuration is a power-of-two width of at least 2 whose
    // stage count was left at its derived value.
    function automatic bit bsh_width_ok(input int width, input int shw);
        return (width >= 2) && ((width & (width - 1)) == 0) && (shw == $clog2(width));
    endfunction

endpackage

`default_nettype wire

// File: rtl/bshift_stage.sv
// ============================================================================
//  Module      : bshift_stage
//  Description : One log2 stage of the barrel shifter: conditional shift by
//                DIST selected by one shamt bit and the op, then a register.
//                Rotate wrap is built only when BSHIFT_ROTATE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bshift_stage
    import bshift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int SHW   = $clog2(WIDTH),
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_shamt,
    input  logic [1:0]       i_op,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [SHW-1:0]   o_shamt,
    output logic [1:0]       o_op,
    output logic [TAG_W-1:0] o_tag
);

    localparam int c_bit = $clog2(DIST);

    logic [WIDTH-1:0] w_shifted;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_shamt;
    logic [1:0]       r_op;
    logic [TAG_W-1:0] r_tag;

    always_comb begin
        w_shifted = i_data;
        if (i_shamt[c_bit]) begin
            case (bsh_op_e'(i_op))
                BSH_SRL: w_shifted = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
                BSH_SRA: w_shifted = {{DIST{i_data[WIDTH-1]}}, i_data[WIDTH-1:DIST]};
`ifdef BSHIFT_ROTATE_EN
                BSH_ROL: w_shifted = {i_data[WIDTH-DIST-1:0], i_data[WIDTH-1:WIDTH-DIST]};
`endif
                // Without the rotate path op 11 falls through to a plain SLL.
                default: w_shifted = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shamt <= '0;
            r_op    <= '0;
            r_tag   <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_shifted;
            r_shamt <= i_shamt;
            r_op    <= i_op;
            r_tag   <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_shamt = r_shamt;
    assign o_op    = r_op;
    assign o_tag   = r_tag;

endmodule

`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
// ============================================================================
//  Module      : barrel_shifter_pipe
//  Description : Pipelined barrel shifter (SLL/SRL/SRA/ROL), one register per
//                log2 stage, valid/ready on both sides with a sideband tag.
//                Optional macro: BSHIFT_ROTATE_EN (enables the ROL wrap path).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shifter_pipe
    import bshift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    if (!bsh_width_ok(WIDTH, SHW)) begin : g_bad_width
        $error("barrel_shifter_pipe: WIDTH must be a power of two >= 2 and SHW must stay derived");
    end

    // Index 0 is the input side; index SHW is the last stage register.
    logic             w_valid [0:SHW];
    logic [WIDTH-1:0] w_data  [0:SHW];
    logic [SHW-1:0]   w_shamt [0:SHW];
    logic [1:0]       w_op    [0:SHW];
    logic [TAG_W-1:0] w_tag   [0:SHW];
    logic             w_adv;
    logic             w_unused_tail;

    // The whole pipe moves as one; bubbles travel with it rather than collapse.
    assign w_adv    = !w_valid[SHW] || out_ready;
    assign in_ready = w_adv && !rst;

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_shamt[0] = in_shamt;
    assign w_op[0]    = in_op;
    assign w_tag[0]   = in_tag;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        bshift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .SHW   (SHW),
            .DIST  (1 << k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_adv),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_shamt (w_shamt[k]),
            .i_op    (w_op[k]),
            .i_tag   (w_tag[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_shamt (w_shamt[k+1]),
            .o_op    (w_op[k+1]),
            .o_tag   (w_tag[k+1])
        );
    end

    assign out_valid = w_valid[SHW];
    assign out_data  = w_data[SHW];
    assign out_tag   = w_tag[SHW];

    // Shamt and op have no consumer past the final stage.
    assign w_unused_tail = ^{w_shamt[SHW], w_op[SHW]};

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
// ============================================================================
//  Module      : tb_barrel_shifter_pipe
//  Description : Directed self-checking bench for barrel_shifter_pipe at
//                WIDTH=32 and WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_barrel_shifter_pipe;

    localparam logic [1:0] c_sll = 2'b00;
    localparam logic [1:0] c_srl = 2'b01;
    localparam logic [1:0] c_sra = 2'b10;
    localparam logic [1:0] c_rol = 2'b11;

`ifdef BSHIFT_ROTATE_EN
    localparam logic [31:0] c_rol_a = 32'h0000_0003;
    localparam logic [31:0] c_rol_b = 32'h2345_6781;
`else
    localparam logic [31:0] c_rol_a = 32'h0000_0002;
    localparam logic [31:0] c_rol_b = 32'h2345_6780;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [4:0]  a_in_shamt;
    logic [1:0]  a_in_op;
    logic [3:0]  a_in_tag, a_out_tag;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_shamt;
    logic [1:0]  b_in_op;
    logic [3:0]  b_in_tag, b_out_tag;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] s_data [8];
    logic [4:0]  s_sh   [8];
    logic [1:0]  s_op   [8];
    logic [31:0] s_exp  [8];

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.WIDTH(32), .TAG_W(4)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_shamt  (a_in_shamt),
        .in_op     (a_in_op),
        .in_tag    (a_in_tag),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_tag   (a_out_tag)
    );

    barrel_shifter_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_shamt  (b_in_shamt),
        .in_op     (b_in_op),
        .in_tag    (b_in_tag),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_tag   (b_out_tag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Single op on the 32-bit instance; latency counts edges from the accept edge.
    task automatic run_one(input string nm, input logic [1:0] op, input logic [31:0] d,
                           input logic [4:0] sh, input logic [3:0] tg, input logic [31:0] exp);
        int cyc;
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_in_op    = op;
        a_in_data  = d;
        a_in_shamt = sh;
        a_in_tag   = tg;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        cyc = 1;
        while (!a_out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, "_lat"}, 32'(cyc), 32'd5);
        check({nm, "_data"}, a_out_data, exp);
        check({nm, "_tag"}, {28'd0, a_out_tag}, {28'd0, tg});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int seen;

        s_data[0] = 32'h0000_00FF; s_sh[0] = 5'd8;  s_op[0] = c_sll; s_exp[0] = 32'h0000_FF00;
        s_data[1] = 32'hF000_0000; s_sh[1] = 5'd28; s_op[1] = c_srl; s_exp[1] = 32'h0000_000F;
        s_data[2] = 32'h8000_0000; s_sh[2] = 5'd31; s_op[2] = c_sra; s_exp[2] = 32'hFFFF_FFFF;
        s_data[3] = 32'h7000_0000; s_sh[3] = 5'd4;  s_op[3] = c_sra; s_exp[3] = 32'h0700_0000;
        s_data[4] = 32'h8000_0001; s_sh[4] = 5'd1;  s_op[4] = c_rol; s_exp[4] = c_rol_a;
        s_data[5] = 32'hDEAD_BEEF; s_sh[5] = 5'd0;  s_op[5] = c_sll; s_exp[5] = 32'hDEAD_BEEF;
        s_data[6] = 32'hDEAD_BEEF; s_sh[6] = 5'd16; s_op[6] = c_srl; s_exp[6] = 32'h0000_DEAD;
        s_data[7] = 32'h1234_5678; s_sh[7] = 5'd4;  s_op[7] = c_rol; s_exp[7] = c_rol_b;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_op = '0; a_in_tag = '0;
        a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_op = '0; b_in_tag = '0;
        b_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_out_data", a_out_data, 32'd0);
        check("rst_out_tag", {28'd0, a_out_tag}, 32'd0);
        check("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
        check("rst_out_valid8", {31'd0, b_out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, a_in_ready}, 32'd1);

        // Single directed ops
        run_one("sll31", c_sll, 32'h0000_0001, 5'd31, 4'd1, 32'h8000_0000);
        run_one("sra4", c_sra, 32'h8000_0000, 5'd4, 4'd2, 32'hF800_0000);
        run_one("srl4", c_srl, 32'h8000_0000, 5'd4, 4'd3, 32'h0800_0000);
        run_one("z_sll", c_sll, 32'hDEAD_BEEF, 5'd0, 4'd4, 32'hDEAD_BEEF);
        run_one("z_srl", c_srl, 32'hDEAD_BEEF, 5'd0, 4'd5, 32'hDEAD_BEEF);
        run_one("z_sra", c_sra, 32'hDEAD_BEEF, 5'd0, 4'd6, 32'hDEAD_BEEF);
        run_one("z_rol", c_rol, 32'hDEAD_BEEF, 5'd0, 4'd7, 32'hDEAD_BEEF);
        run_one("rol1", c_rol, 32'h8000_0001, 5'd1, 4'd8, c_rol_a);

        // Back-to-back stream with a 3-cycle output stall
        @(posedge clk); #1;
        fork
            begin : drv
                for (int i = 0; i < 8; i++) begin
                    logic acc;
                    int   guard;
                    a_in_valid = 1'b1;
                    a_in_data  = s_data[i];
                    a_in_shamt = s_sh[i];
                    a_in_op    = s_op[i];
                    a_in_tag   = 4'(i);
                    guard = 0;
                    do begin
                        @(negedge clk);
                        acc = a_in_ready;
                        @(posedge clk); #1;
                        guard++;
                    end while (!acc && guard < 50);
                    if (!acc) check("stream_accept_timeout", 32'd0, 32'd1);
                end
                a_in_valid = 1'b0;
            end
            begin : stall
                repeat (7) @(posedge clk);
                #1;
                a_out_ready = 1'b0;
                #1;
                check("stall_in_ready", {31'd0, a_in_ready}, 32'd0);
                check("stall_valid", {31'd0, a_out_valid}, 32'd1);
                check("stall_tag", {28'd0, a_out_tag}, 32'd2);
                check("stall_data", a_out_data, s_exp[2]);
                repeat (2) begin
                    @(posedge clk); #2;
                    check("stall_hold_ready", {31'd0, a_in_ready}, 32'd0);
                    check("stall_hold_valid", {31'd0, a_out_valid}, 32'd1);
                    check("stall_hold_tag", {28'd0, a_out_tag}, 32'd2);
                    check("stall_hold_data", a_out_data, s_exp[2]);
                end
                @(posedge clk); #1;
                a_out_ready = 1'b1;
            end
            begin : col
                int got;
                int cycles;
                got = 0;
                cycles = 0;
                while (got < 8 && cycles < 100) begin
                    @(negedge clk);
                    cycles++;
                    if (a_out_valid && a_out_ready) begin
                        check("stream_tag", {28'd0, a_out_tag}, 32'(got));
                        check("stream_data", a_out_data, s_exp[got]);
                        got++;
                    end
                end
                check("stream_count", 32'(got), 32'd8);
            end
        join

        // Reset with three ops in flight, plus an op offered during reset
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_op    = c_sll;
            a_in_data  = 32'(i + 1);
            a_in_shamt = 5'd1;
            a_in_tag   = 4'(4'hA + i);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        a_in_tag = 4'hF;
        #1;
        check("rstpulse_in_ready", {31'd0, a_in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_in_valid = 1'b0;
        check("rstpulse_out_valid", {31'd0, a_out_valid}, 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        check("rstpulse_no_emit", 32'(seen), 32'd0);
        run_one("post_rst", c_srl, 32'hDEAD_BEEF, 5'd16, 4'd9, 32'h0000_DEAD);

        // WIDTH=8 instance
        @(posedge clk); #1;
        b_in_valid = 1'b1;
        b_in_op    = c_sra;
        b_in_data  = 8'h90;
        b_in_shamt = 3'd3;
        b_in_tag   = 4'd5;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        cyc = 1;
        while (!b_out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w8_lat", 32'(cyc), 32'd3);
        check("w8_data", {24'd0, b_out_data}, 32'h0000_00F2);
        check("w8_tag", {28'd0, b_out_tag}, 32'd5);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
